instr_prefetch: RTL and testbench

INSTR_PREFETCH -- requirements
Module: instr_prefetch

---
 rtl/core_pkg.sv | 7 +
 rtl/instr_prefetch_if.sv | 10 +
 rtl/fetch_queue.sv | 54 +++++
 rtl/instr_prefetch.sv | 62 ++++++
 tb/tb_instr_prefetch.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared core widths and the instruction word type
package core_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam int INSTR_BYTES = 4;
  typedef logic [ILEN-1:0] instr_t;
endpackage

// File: rtl/instr_prefetch_if.sv
// instr_prefetch_if: in-order instruction memory request/response channel
interface instr_prefetch_if #(parameter int XLEN = core_pkg::XLEN) ();
  logic req_valid;
  logic req_ready;
  logic [XLEN-1:0] req_addr;
  logic resp_valid;
  core_pkg::instr_t resp_data;
  modport master (output req_valid, req_addr, input req_ready, resp_valid, resp_data);
  modport slave (input req_valid, req_addr, output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of requested PCs, filled in order as responses arrive
module fetch_queue import core_pkg::*; #(
  parameter int XLEN = core_pkg::XLEN,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic fill,
  input  instr_t fill_data,
  input  logic pop,
  output logic [AW:0] count,
  output logic head_valid,
  output logic [XLEN-1:0] head_pc,
  output instr_t head_data
);
  logic [XLEN-1:0] pc_q [DEPTH];
  instr_t data_q [DEPTH];
  logic [DEPTH-1:0] has_data;
  logic [AW-1:0] alloc_ptr, fill_ptr, pop_ptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alloc_ptr <= '0;
      fill_ptr <= '0;
      pop_ptr <= '0;
      count <= '0;
      has_data <= '0;
    end else if (flush) begin
      alloc_ptr <= '0;
      fill_ptr <= '0;
      pop_ptr <= '0;
      count <= '0;
      has_data <= '0;
    end else begin
      alloc_ptr <= alloc ? alloc_ptr + AW'(1) : alloc_ptr;
      fill_ptr <= fill ? fill_ptr + AW'(1) : fill_ptr;
      pop_ptr <= pop ? pop_ptr + AW'(1) : pop_ptr;
      count <= count + (AW+1)'(alloc) - (AW+1)'(pop);
      has_data <= (has_data | (DEPTH'(fill) << fill_ptr)) & ~(DEPTH'(pop) << pop_ptr);
    end
  always_ff @(posedge clk) begin
    if (alloc) pc_q[alloc_ptr] <= alloc_pc;
    if (fill) data_q[fill_ptr] <= fill_data;
  end
  // storage is not reset, so the head is masked to zero whenever it holds no data
  always_comb begin
    head_valid = has_data[pop_ptr];
    head_pc = head_valid ? pc_q[pop_ptr] : '0;
    head_data = head_valid ? data_q[pop_ptr] : '0;
  end
endmodule

// File: rtl/instr_prefetch.sv
// instr_prefetch: fetches sequential instruction words into a bounded queue, flushing on redirect
module instr_prefetch import core_pkg::*; #(
  parameter int XLEN = core_pkg::XLEN,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pc_src_exec,
  input  logic [XLEN-1:0] pc_target_exec,
  instr_prefetch_if.master imem,
  input  logic stall_decode,
  output logic valid_decode,
  output instr_t instr_decode,
  output logic [XLEN-1:0] pc_decode,
  output logic [XLEN-1:0] next_pc_decode
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = 16;
  logic [XLEN-1:0] fetch_pc, head_pc;
  logic [CW-1:0] q_count, outstanding;
  logic [DW-1:0] drop_cnt;
  logic accept, fill, pop;
  // queue entries are allocated at request time, so q_count already covers occupancy plus outstanding
  always_comb begin
    imem.req_addr = fetch_pc;
    imem.req_valid = rst_n && !pc_src_exec && q_count < CW'(DEPTH);
    accept = imem.req_valid && imem.req_ready;
    fill = imem.resp_valid && !pc_src_exec && drop_cnt == '0;
    pop = valid_decode && !stall_decode && !pc_src_exec;
    pc_decode = head_pc;
    next_pc_decode = valid_decode ? head_pc + XLEN'(INSTR_BYTES) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
    end else if (pc_src_exec) begin
      fetch_pc <= pc_target_exec & ~XLEN'(INSTR_BYTES - 1);
      outstanding <= '0;
      drop_cnt <= drop_cnt + DW'(outstanding) - DW'(imem.resp_valid);
    end else begin
      fetch_pc <= accept ? fetch_pc + XLEN'(INSTR_BYTES) : fetch_pc;
      outstanding <= outstanding + CW'(accept) - CW'(fill);
      drop_cnt <= drop_cnt - DW'(imem.resp_valid && drop_cnt != '0);
    end
  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) u_queue (
    .clk(clk),
    .rst_n(rst_n),
    .flush(pc_src_exec),
    .alloc(accept),
    .alloc_pc(fetch_pc),
    .fill(fill),
    .fill_data(imem.resp_data),
    .pop(pop),
    .count(q_count),
    .head_valid(valid_decode),
    .head_pc(head_pc),
    .head_data(instr_decode)
  );
endmodule

// File: tb/tb_instr_prefetch.sv
// tb_instr_prefetch: randomized and directed checks of instr_prefetch against a PC-stream model
module tb_instr_prefetch;
  localparam int DEPTH = 4;
  typedef struct {int due; logic [31:0] addr;} mreq_t;
  logic clk = 0, rst_n = 1, pc_src_exec = 0, stall_decode = 0, valid_decode;
  logic [31:0] pc_target_exec = 0, pc_decode, next_pc_decode, instr_decode;
  logic [31:0] exp_pc;
  int n_checks = 0, n_fail = 0, cyc = 0, lat = 1;
  mreq_t mq[$];
  instr_prefetch_if #(.XLEN(32)) imem ();
  instr_prefetch #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .pc_src_exec(pc_src_exec), .pc_target_exec(pc_target_exec),
    .imem(imem), .stall_decode(stall_decode), .valid_decode(valid_decode),
    .instr_decode(instr_decode), .pc_decode(pc_decode), .next_pc_decode(next_pc_decode));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction
  // memory: records handshakes mid-cycle, answers in order after lat cycles
  always @(negedge clk)
    if (rst_n && imem.req_valid && imem.req_ready) mq.push_back('{cyc + lat, imem.req_addr});
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst_n) begin
      mq.delete();
      imem.resp_valid = 0;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem.resp_valid = 1;
      imem.resp_data = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else imem.resp_valid = 0;
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic apply_reset();
    rst_n = 0; pc_src_exec = 0; pc_target_exec = 0; stall_decode = 0; imem.req_ready = 1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1;
    exp_pc = 0;
  endtask
  task automatic test_reset();
    imem.req_ready = 1;
    #1 rst_n = 0;
    #1;
    n_checks++; if (imem.req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", imem.req_valid); end
    n_checks++; if (valid_decode !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_decode); end
    n_checks++; if (pc_decode !== 0 || next_pc_decode !== 0 || instr_decode !== 0) begin n_fail++; $display("FAIL reset_outs: pc %h next %h instr %h want all 0", pc_decode, next_pc_decode, instr_decode); end
    n_checks++; if (imem.req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem.req_addr); end
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    #1;
    n_checks++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h0) begin n_fail++; $display("FAIL first_req: valid %b addr %h want 1 0", imem.req_valid, imem.req_addr); end
  endtask
  task automatic test_stream();
    lat = 1;
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++; if (valid_decode !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid c%0d: got %b want 0", k, valid_decode); end
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (valid_decode !== 1'b1 || pc_decode !== 32'(4 * k) || next_pc_decode !== 32'(4 * k + 4) || instr_decode !== mem_word(32'(4 * k))) begin
        n_fail++;
        $display("FAIL stream c%0d: valid %b pc %h next %h instr %h want 1 %h %h %h", k + 2, valid_decode, pc_decode, next_pc_decode, instr_decode, 32'(4 * k), 32'(4 * k + 4), mem_word(32'(4 * k)));
      end
    end
  endtask
  task automatic test_stall();
    int acc = 0;
    lat = 1;
    apply_reset();
    stall_decode = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (imem.req_valid && imem.req_ready) acc++;
      if (k >= 2) begin
        n_checks++;
        if (valid_decode !== 1'b1 || pc_decode !== 32'h0 || instr_decode !== mem_word(0)) begin n_fail++; $display("FAIL stall_hold c%0d: valid %b pc %h instr %h want 1 0 %h", k, valid_decode, pc_decode, instr_decode, mem_word(0)); end
      end
    end
    n_checks++; if (acc != DEPTH) begin n_fail++; $display("FAIL stall_accepts: got %0d want %0d", acc, DEPTH); end
    tick();
    stall_decode = 0;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      n_checks++;
      if (valid_decode !== 1'b1 || pc_decode !== 32'(4 * k)) begin n_fail++; $display("FAIL stall_drain %0d: valid %b pc %h want 1 %h", k, valid_decode, pc_decode, 32'(4 * k)); end
    end
  endtask
  task automatic test_redirect();
    bit found;
    lat = 3;
    apply_reset();
    tick();
    tick();
    pc_src_exec = 1; pc_target_exec = 32'h0000_0102;
    @(negedge clk);
    n_checks++; if (imem.req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_req: got %b want 0", imem.req_valid); end
    tick();
    pc_src_exec = 0;
    @(negedge clk);
    n_checks++; if (valid_decode !== 1'b0 || imem.req_addr !== 32'h100) begin n_fail++; $display("FAIL redir_after: valid %b addr %h want 0 100", valid_decode, imem.req_addr); end
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin @(negedge clk); found = valid_decode; end
    n_checks++;
    if (!found || pc_decode !== 32'h100 || instr_decode !== mem_word(32'h100)) begin n_fail++; $display("FAIL redir_first: found %b pc %h instr %h want 1 100 %h", found, pc_decode, instr_decode, mem_word(32'h100)); end
    tick();
    pc_src_exec = 1; pc_target_exec = 32'h200;
    tick();
    pc_target_exec = 32'h304;
    tick();
    pc_src_exec = 0;
    @(negedge clk);
    n_checks++; if (valid_decode !== 1'b0) begin n_fail++; $display("FAIL redir2_after: valid %b want 0", valid_decode); end
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin @(negedge clk); found = valid_decode; end
    n_checks++;
    if (!found || pc_decode !== 32'h304 || instr_decode !== mem_word(32'h304)) begin n_fail++; $display("FAIL redir2_first: found %b pc %h instr %h want 1 304 %h", found, pc_decode, instr_decode, mem_word(32'h304)); end
  endtask
  task automatic test_wrap();
    bit found;
    lat = 1;
    apply_reset();
    tick();
    pc_src_exec = 1; pc_target_exec = 32'hFFFF_FFFE;
    tick();
    pc_src_exec = 0;
    @(negedge clk);
    n_checks++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr: valid %b addr %h want 1 fffffffc", imem.req_valid, imem.req_addr); end
    @(negedge clk);
    n_checks++; if (imem.req_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next_addr: got %h want 0", imem.req_addr); end
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin @(negedge clk); found = valid_decode; end
    n_checks++;
    if (!found || pc_decode !== 32'hFFFF_FFFC || next_pc_decode !== 32'h0) begin n_fail++; $display("FAIL wrap_decode: found %b pc %h next %h want 1 fffffffc 0", found, pc_decode, next_pc_decode); end
    @(negedge clk);
    n_checks++; if (valid_decode !== 1'b1 || pc_decode !== 32'h0 || next_pc_decode !== 32'h4) begin n_fail++; $display("FAIL wrap_follow: valid %b pc %h next %h want 1 0 4", valid_decode, pc_decode, next_pc_decode); end
  endtask
  task automatic test_random();
    int live = 0, pops = 0;
    bit was_redir = 0;
    lat = 3;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      tick();
      imem.req_ready = $urandom_range(0, 3) != 0;
      stall_decode = $urandom_range(0, 3) == 0;
      pc_src_exec = $urandom_range(0, 15) == 0;
      pc_target_exec = $urandom;
      @(negedge clk);
      if (was_redir) begin
        n_checks++; if (valid_decode !== 1'b0) begin n_fail++; $display("FAIL rand_post_redir c%0d: valid %b want 0", c, valid_decode); end
      end
      if (pc_src_exec) begin
        exp_pc = {pc_target_exec[31:2], 2'b00};
        live = 0;
      end else begin
        if (imem.req_valid && imem.req_ready) live++;
        if (valid_decode && !stall_decode) begin
          n_checks++;
          if (pc_decode !== exp_pc || next_pc_decode !== exp_pc + 32'd4 || instr_decode !== mem_word(exp_pc)) begin
            n_fail++;
            $display("FAIL rand_pop c%0d: pc %h next %h instr %h want %h %h %h", c, pc_decode, next_pc_decode, instr_decode, exp_pc, exp_pc + 32'd4, mem_word(exp_pc));
          end
          exp_pc += 4;
          pops++;
          live--;
        end
        n_checks++; if (live > DEPTH) begin n_fail++; $display("FAIL rand_bound c%0d: in flight %0d want <= %0d", c, live, DEPTH); end
      end
      was_redir = pc_src_exec;
    end
    n_checks++; if (pops < 60) begin n_fail++; $display("FAIL rand_progress: pops %0d want >= 60", pops); end
    pc_src_exec = 0; stall_decode = 0; imem.req_ready = 1;
  endtask
  task automatic test_async_reset();
    bit found;
    lat = 1;
    apply_reset();
    repeat (6) @(posedge clk);
    #3 rst_n = 0;
    #1;
    n_checks++; if (valid_decode !== 1'b0 || imem.req_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valids: valid %b req %b want 0 0", valid_decode, imem.req_valid); end
    n_checks++; if (pc_decode !== 0 || next_pc_decode !== 0 || instr_decode !== 0 || imem.req_addr !== 0) begin n_fail++; $display("FAIL areset_outs: pc %h next %h instr %h addr %h want all 0", pc_decode, next_pc_decode, instr_decode, imem.req_addr); end
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    #1;
    n_checks++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h0) begin n_fail++; $display("FAIL areset_resume: valid %b addr %h want 1 0", imem.req_valid, imem.req_addr); end
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin @(negedge clk); found = valid_decode; end
    n_checks++;
    if (!found || pc_decode !== 32'h0 || instr_decode !== mem_word(0)) begin n_fail++; $display("FAIL areset_first: found %b pc %h instr %h want 1 0 %h", found, pc_decode, instr_decode, mem_word(0)); end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
